// File: rtl/unary_add_seq_pkg.sv
// Shared types and constants for the unary adder operand sequencer.
// Holds the FSM state encoding, default phase lengths, operand/result
// types and the carry threshold used by the optional self-check.
package unary_add_seq_pkg;

    localparam int DIGIT_MAX_DEF = 4;
    localparam int WR_MAX_DEF    = 8;
    localparam int CARRY_THRESH  = 5;

    typedef logic [2:0] operand_t;
    typedef logic [3:0] result_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        FLUSH,
        WRITE,
        DONE
    } state_t;

    // Limit an incoming operand to the longest stream the read phase can carry
    function automatic operand_t clamp_digit(input operand_t v, input int max_val);
        return (v > operand_t'(max_val)) ? operand_t'(max_val) : v;
    endfunction

endpackage

// File: rtl/unary_ser.sv
// Operand-to-stream serialiser: turns a binary digit into a front-packed
// unary bit for a given read-phase index (bit is 1 while idx < value).
module unary_ser
    import unary_add_seq_pkg::*;
(
    input  operand_t   val_a,
    input  operand_t   val_b,
    input  logic [2:0] idx,
    output logic       bit_a,
    output logic       bit_b
);

    // Thermometer decode of both operands at the requested stream position
    always_comb begin
        bit_a = (idx < val_a);
        bit_b = (idx < val_b);
    end

endmodule

// File: rtl/unary_add_seq.sv
// Operand sequencer and result collector for the serial unary adder.
// Accepts an operand pair, streams it to the adder in unary form, counts
// the returned dout pulses, captures the carry and hands back the result.
// Optional macro UNARY_SEQ_CHECK_EN adds a sticky self-check on err.
module unary_add_seq
    import unary_add_seq_pkg::*;
#(
    parameter int DIGIT_MAX = DIGIT_MAX_DEF,
    parameter int WR_MAX    = WR_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op_a,
    input  logic [2:0] op_b,
    output logic       A,
    output logic       B,
    output logic       en,
    output logic       read_or_write,
    input  logic       dout,
    input  logic       C,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] res_sum,
    output logic       res_carry,
    output logic       busy,
    output logic       err
);

    localparam logic [2:0] RD_LAST = 3'(DIGIT_MAX - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_MAX - 1);

    state_t     state;
    operand_t   a_lat;
    operand_t   b_lat;
    logic [2:0] rd_idx;
    logic [3:0] wr_idx;
    logic       flush_idx;

    operand_t   ser_a;
    operand_t   ser_b;
    logic [2:0] ser_idx;
    logic       ser_bit_a;
    logic       ser_bit_b;

    result_t    sum_next;
    logic       carry_next;
    logic       wr_exit;

    // Serialiser looks at the fresh clamped operands on accept, otherwise the
    // latched ones one step ahead, so A/B can be registered for the next cycle
    always_comb begin
        ser_a   = a_lat;
        ser_b   = b_lat;
        ser_idx = rd_idx + 3'd1;
        if (state == IDLE) begin
            ser_a   = clamp_digit(op_a, DIGIT_MAX);
            ser_b   = clamp_digit(op_b, DIGIT_MAX);
            ser_idx = 3'd0;
        end
    end

    unary_ser u_ser (
        .val_a (ser_a),
        .val_b (ser_b),
        .idx   (ser_idx),
        .bit_a (ser_bit_a),
        .bit_b (ser_bit_b)
    );

    // Write-phase bookkeeping: saturating pulse count, carry capture, exit test
    always_comb begin
        sum_next   = res_sum;
        carry_next = res_carry;
        if (dout && (res_sum != 4'hF)) begin
            sum_next = res_sum + 4'd1;
        end
        if (wr_idx == 4'd0) begin
            carry_next = res_carry | C;
        end
        wr_exit = ((wr_idx != 4'd0) && !dout) || (wr_idx == WR_LAST);
    end

    // Main sequencer; every output is registered alongside the state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            A             <= 1'b0;
            B             <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            res_sum       <= '0;
            res_carry     <= 1'b0;
            a_lat         <= '0;
            b_lat         <= '0;
            rd_idx        <= '0;
            wr_idx        <= '0;
            flush_idx     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_lat     <= ser_a;
                        b_lat     <= ser_b;
                        res_sum   <= '0;
                        res_carry <= 1'b0;
                        rd_idx    <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        en        <= 1'b1;
                        A         <= ser_bit_a;
                        B         <= ser_bit_b;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (rd_idx == RD_LAST) begin
                        A         <= 1'b0;
                        B         <= 1'b0;
                        flush_idx <= 1'b0;
                        state     <= FLUSH;
                    end else begin
                        rd_idx <= rd_idx + 3'd1;
                        A      <= ser_bit_a;
                        B      <= ser_bit_b;
                    end
                end
                FLUSH: begin
                    res_carry <= res_carry | C;
                    if (flush_idx) begin
                        wr_idx        <= '0;
                        read_or_write <= 1'b1;
                        state         <= WRITE;
                    end else begin
                        flush_idx <= 1'b1;
                    end
                end
                WRITE: begin
                    res_sum   <= sum_next;
                    res_carry <= carry_next;
                    if (wr_exit) begin
                        en            <= 1'b0;
                        read_or_write <= 1'b0;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wr_idx <= wr_idx + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UNARY_SEQ_CHECK_EN
    localparam logic [3:0] CARRY_LIM = 4'(CARRY_THRESH);
    logic [3:0] exp_total;

    assign exp_total = {1'b0, a_lat} + {1'b0, b_lat};

    // Compare the collected result with the latched operands as DONE is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((state == WRITE) && wr_exit) begin
            if ((sum_next != {1'b0, exp_total[2:0]}) ||
                (carry_next != (exp_total >= CARRY_LIM))) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
